// File: rtl/mul_feeder_pkg.sv
// Shared constants and FSM encoding for the MUL input feeder.
// Word layout, LSB first: activation, weight, zero-mask.
package mul_feeder_pkg;
  localparam int DEF_GROUP_SIZE             = 4;
  localparam int DEF_DATA_WIDTH             = 8;
  localparam int DEF_LOG_MAX_ITERS          = 16;
  localparam int DEF_LOG_MAX_READS_PER_ITER = 16;

  function automatic int out_width(input int gs, input int dw);
    return 2*dw + gs;
  endfunction

  localparam int DEF_OUTPUT_WIDTH = out_width(DEF_GROUP_SIZE, DEF_DATA_WIDTH);
  localparam int ACT_LSB = 0;
  localparam int W_LSB   = DEF_DATA_WIDTH;
  localparam int ZI_LSB  = 2*DEF_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_W = 2'd1, WAIT_A = 2'd2, SEND = 2'd3} state_t;
endpackage

// File: rtl/mul_feeder_if.sv
// Feeder -> MUL word bus with valid/avail handshake.
interface mul_feeder_if #(parameter int W = mul_feeder_pkg::DEF_OUTPUT_WIDTH);
  logic [W-1:0] data;
  logic         valid;
  logic         avail;
  modport master (output data, valid, input avail);
  modport slave  (input data, valid, output avail);
endinterface

// File: rtl/mul_feeder_group_serializer.sv
// Holds one activation group and walks its lanes; the zero-mask is
// computed once at load so every word of the group carries the same mask.
module mul_feeder_group_serializer import mul_feeder_pkg::*; #(
  parameter int GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] i_group,
  input  logic                       i_advance,
  output logic [DATA_WIDTH-1:0]      o_lane_data,
  output logic [GROUP_SIZE-1:0]      o_mask,
  output logic                       o_last
);
  localparam int LW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  logic [GROUP_SIZE*DATA_WIDTH-1:0] r_group;
  logic [GROUP_SIZE-1:0]            r_mask;
  logic [LW-1:0]                    r_lane;
  logic [GROUP_SIZE-1:0]            w_mask;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < GROUP_SIZE; i++)
      w_mask[i] = (i_group[i*DATA_WIDTH +: DATA_WIDTH] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_group <= '0;
      r_mask  <= '0;
      r_lane  <= '0;
    end else if (i_load) begin
      r_group <= i_group;
      r_mask  <= w_mask;
      r_lane  <= '0;
    end else if (i_advance) begin
      r_lane  <= r_lane + 1'b1;
    end
  end

  assign o_lane_data = r_group[r_lane*DATA_WIDTH +: DATA_WIDTH];
  assign o_mask      = r_mask;
  assign o_last      = (r_lane == LW'(GROUP_SIZE-1));
endmodule

// File: rtl/mul_feeder.sv
// MUL input feeder: takes one weight per iteration and activation groups,
// and emits GROUP_SIZE packed words per group under MUL backpressure.
module mul_feeder import mul_feeder_pkg::*; #(
  parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_configure,
  input  logic [LOG_MAX_ITERS-1:0]          i_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] i_num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]  i_act,
  input  logic                              i_act_valid,
  output logic                              o_act_avail,
  input  logic [DATA_WIDTH-1:0]             i_weight,
  input  logic                              i_weight_valid,
  output logic                              o_weight_avail,
  output logic                              o_done,
  mul_feeder_if.master                      mul
);
  localparam int OUTPUT_WIDTH = out_width(GROUP_SIZE, DATA_WIDTH);

  state_t                            r_state;
  logic [LOG_MAX_ITERS-1:0]          r_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] r_reads, r_reads_cfg;
  logic [DATA_WIDTH-1:0]             r_weight;
  logic [OUTPUT_WIDTH-1:0]           r_data;
  logic                              r_valid, r_done;

  logic                  w_load, w_adv, w_last;
  logic [DATA_WIDTH-1:0] w_lane_data;
  logic [GROUP_SIZE-1:0] w_mask;

  // configure wins over any handshake landing in the same cycle
  assign w_load = (r_state == WAIT_A) && i_act_valid && !i_configure;
  assign w_adv  = (r_state == SEND) && mul.avail && !i_configure;

  mul_feeder_group_serializer #(.GROUP_SIZE(GROUP_SIZE), .DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk(clk), .rst(rst), .i_load(w_load), .i_group(i_act), .i_advance(w_adv),
    .o_lane_data(w_lane_data), .o_mask(w_mask), .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_iters     <= '0;
      r_reads     <= '0;
      r_reads_cfg <= '0;
      r_weight    <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (i_configure) begin
        if (i_num_iters != '0 && i_num_reads_per_iter != '0) begin
          r_iters     <= i_num_iters;
          r_reads     <= i_num_reads_per_iter;
          r_reads_cfg <= i_num_reads_per_iter;
          r_state     <= WAIT_W;
        end else begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          WAIT_W: if (i_weight_valid) begin
            r_weight <= i_weight;
            r_state  <= WAIT_A;
          end
          WAIT_A: if (i_act_valid) r_state <= SEND;
          SEND: if (mul.avail) begin
            r_data  <= {w_mask, r_weight, w_lane_data};
            r_valid <= 1'b1;
            if (w_last) begin
              if (r_reads != 1) begin
                r_reads <= r_reads - 1'b1;
                r_state <= WAIT_A;
              end else if (r_iters != 1) begin
                r_iters <= r_iters - 1'b1;
                r_reads <= r_reads_cfg;
                r_state <= WAIT_W;
              end else begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_weight_avail = (r_state == WAIT_W);
  assign o_act_avail    = (r_state == WAIT_A);
  assign o_done         = r_done;
  assign mul.data       = r_data;
  assign mul.valid      = r_valid;
endmodule
